// File: rtl/sram_loader.sv
// Boot loader: receives a length-prefixed UART byte stream, writes halfwords into
// external SRAM with a registered write strobe, then releases the core and passes its SRAM pins through.
module sram_loader #(
  parameter logic [17:0] BASE      = 18'h00000,
  parameter int          WR_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        start,
  input  logic [17:0] cpu_addr,
  input  logic        cpu_wre,
  output logic [17:0] ram_addr,
  output logic        ram_wre,
  inout  wire  [15:0] ram_data,
  output logic        cpu_reset_n,
  output logic        loading,
  output logic        done,
  output logic        overrun
);

  localparam int CW = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_LEN0, S_LEN1, S_LO, S_HI, S_SETUP, S_PULSE, S_HOLD, S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [15:0]   r_len;
  logic [15:0]   r_idx;
  logic [7:0]    r_lo;
  logic [15:0]   r_word;
  logic [17:0]   r_addr;
  logic [CW-1:0] r_cnt;
  logic          r_wre;
  logic          r_oe;
  logic          r_cpu_rst_n;
  logic          r_overrun;
  logic [15:0]   w_idx_inc;
  logic          w_in_write;
  logic          w_done;

  assign w_idx_inc  = r_idx + 16'd1;
  assign w_in_write = (r_state == S_SETUP) || (r_state == S_PULSE) || (r_state == S_HOLD);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_LEN0;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LEN0:  if (rx_valid) w_next = S_LEN1;
      S_LEN1:  if (rx_valid) w_next = ({rx_data, r_len[7:0]} == 16'd0) ? S_DONE : S_LO;
      S_LO:    if (rx_valid) w_next = S_HI;
      S_HI:    if (rx_valid) w_next = S_SETUP;
      S_SETUP: w_next = S_PULSE;
      S_PULSE: if (r_cnt == CW'(WR_CYCLES - 1)) w_next = S_HOLD;
      S_HOLD:  w_next = (w_idx_inc == r_len) ? S_DONE : S_LO;
      S_DONE:  if (start) w_next = S_LEN0;
      default: w_next = S_LEN0;
    endcase
  end

  // Strobe, bus enable and core reset are registered from the next state so they never glitch.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_len       <= '0;
      r_idx       <= '0;
      r_lo        <= '0;
      r_word      <= '0;
      r_addr      <= BASE;
      r_cnt       <= '0;
      r_wre       <= 1'b1;
      r_oe        <= 1'b0;
      r_cpu_rst_n <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_wre       <= (w_next != S_PULSE);
      r_oe        <= (w_next == S_SETUP) || (w_next == S_PULSE) || (w_next == S_HOLD);
      r_cpu_rst_n <= (w_next == S_DONE);
      case (r_state)
        S_LEN0: if (rx_valid) r_len[7:0] <= rx_data;
        S_LEN1: if (rx_valid) begin
          r_len[15:8] <= rx_data;
          r_idx       <= '0;
        end
        S_LO:   if (rx_valid) r_lo <= rx_data;
        S_HI:   if (rx_valid) begin
          r_word <= {rx_data, r_lo};
          r_addr <= BASE + {2'b00, r_idx};
        end
        S_SETUP: r_cnt <= '0;
        S_PULSE: r_cnt <= r_cnt + CW'(1);
        S_HOLD:  r_idx <= w_idx_inc;
        default: ;
      endcase
      if (w_in_write && rx_valid)
        r_overrun <= 1'b1;
      else if (r_state == S_DONE && start)
        r_overrun <= 1'b0;
    end
  end

  always_comb begin
    w_done      = (r_state == S_DONE);
    ram_addr    = w_done ? cpu_addr : r_addr;
    ram_wre     = w_done ? cpu_wre  : r_wre;
    cpu_reset_n = r_cpu_rst_n;
    loading     = !w_done;
    done        = w_done;
    overrun     = r_overrun;
  end

  assign ram_data = r_oe ? r_word : 16'hzzzz;

endmodule

// File: tb/tb_sram_loader.sv
// Bench for sram_loader: table-driven loads with a write scoreboard, plus hand sequences
// for zero length, overrun, DONE passthrough, restart and reset during a write.
module tb_sram_loader;

  localparam logic [17:0] BASE      = 18'h00000;
  localparam int          WR_CYCLES = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        start;
  logic [17:0] cpu_addr;
  logic        cpu_wre;
  logic [17:0] ram_addr;
  logic        ram_wre;
  wire  [15:0] ram_data;
  logic        cpu_reset_n;
  logic        loading;
  logic        done;
  logic        overrun;

  pullup pu_bus (ram_data);

  always #5 clock = ~clock;

  sram_loader #(.BASE(BASE), .WR_CYCLES(WR_CYCLES)) dut (
    .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .start(start), .cpu_addr(cpu_addr), .cpu_wre(cpu_wre),
    .ram_addr(ram_addr), .ram_wre(ram_wre), .ram_data(ram_data),
    .cpu_reset_n(cpu_reset_n), .loading(loading), .done(done), .overrun(overrun)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int wr_count = 0;

  typedef struct packed {
    logic [17:0] addr;
    logic [15:0] data;
  } wr_t;
  wr_t exp_q[$];

  typedef struct {
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [15:0] exp_word;
  } word_vec_t;

  typedef struct {
    logic [17:0] addr;
    logic        wre;
  } pass_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_word(input int idx, input logic [15:0] w);
    wr_t e;
    e.addr = BASE + 18'(idx);
    e.data = w;
    exp_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clock);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clock);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clock);
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 200 && done !== 1'b1; i++) @(negedge clock);
    check(name, done, 1'b1);
  endtask

  // Write monitor: each ram_wre low run while loading is one transaction.
  logic [17:0] prev_addr, cap_addr;
  logic [15:0] prev_data, cap_data;
  int          low_cnt = 0;
  wr_t         e_mon;

  always @(negedge clock) begin
    if (loading === 1'b1 && ram_wre === 1'b0) begin
      if (low_cnt == 0) begin
        cap_addr = ram_addr;
        cap_data = ram_data;
        check("addr_setup_stable", prev_addr, ram_addr);
        check("data_setup_stable", prev_data, ram_data);
      end else begin
        check("addr_pulse_stable", ram_addr, cap_addr);
        check("data_pulse_stable", ram_data, cap_data);
      end
      low_cnt++;
    end else if (low_cnt != 0) begin
      if (reset === 1'b1) begin
        check("addr_hold_stable", ram_addr, cap_addr);
        check("data_hold_stable", ram_data, cap_data);
      end
      check("pulse_len", low_cnt, WR_CYCLES);
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL sb_unexpected_write: got addr %05h data %04h, required none", cap_addr, cap_data);
      end else begin
        e_mon = exp_q.pop_front();
        check("wr_addr", cap_addr, e_mon.addr);
        check("wr_data", cap_data, e_mon.data);
      end
      $display("write %0d addr=%05h data=%04h low_cycles=%0d", wr_count, cap_addr, cap_data, low_cnt);
      wr_count++;
      low_cnt = 0;
    end
    prev_addr = ram_addr;
    prev_data = ram_data;
  end

  word_vec_t wv[2];
  pass_vec_t pv[4];
  int        wc;

  initial begin
    wv[0] = '{lo: 8'h34, hi: 8'h12, exp_word: 16'h1234};
    wv[1] = '{lo: 8'hCD, hi: 8'hAB, exp_word: 16'hABCD};
    pv[0] = '{addr: 18'h2AAAA, wre: 1'b1};
    pv[1] = '{addr: 18'h2AAAA, wre: 1'b0};
    pv[2] = '{addr: 18'h15555, wre: 1'b0};
    pv[3] = '{addr: 18'h3FFFF, wre: 1'b1};

    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; start = 1'b0;
    cpu_addr = 18'h00000; cpu_wre = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("rst_ram_wre", ram_wre, 1'b1);
    check("rst_ram_data_z", ram_data, 16'hFFFF);
    check("rst_ram_addr", ram_addr, BASE);
    check("rst_cpu_reset_n", cpu_reset_n, 1'b0);
    check("rst_loading", loading, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (20) @(negedge clock);
    check("idle_no_write", wr_count, 0);
    check("idle_bus_z", ram_data, 16'hFFFF);

    // Two-word load from the table, 10-cycle byte spacing.
    send_byte(8'h02, 10);
    send_byte(8'h00, 10);
    for (int i = 0; i < 2; i++) begin
      send_byte(wv[i].lo, 10);
      push_word(i, wv[i].exp_word);
      send_byte(wv[i].hi, (i == 1) ? 0 : 10);
    end
    repeat (3) @(negedge clock);
    check("done_before_hold_exit", done, 1'b0);
    check("cpurst_before_hold_exit", cpu_reset_n, 1'b0);
    @(negedge clock);
    check("done_at_hold_exit", done, 1'b1);
    check("cpurst_at_hold_exit", cpu_reset_n, 1'b1);
    check("load2_overrun", overrun, 1'b0);
    check("load2_writes", wr_count, 2);

    // Zero-length stream goes straight to DONE.
    pulse_start();
    wc = wr_count;
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check("zero_len_done", done, 1'b1);
    repeat (8) @(negedge clock);
    check("zero_len_no_write", wr_count, wc);

    // Byte injected during PULSE of word 0.
    pulse_start();
    send_byte(8'h02, 2);
    send_byte(8'h00, 2);
    send_byte(8'h11, 2);
    push_word(0, 16'h2211);
    send_byte(8'h22, 0);
    @(negedge clock);
    rx_valid = 1'b1;
    rx_data  = 8'h99;
    @(negedge clock);
    rx_valid = 1'b0;
    check("overrun_set", overrun, 1'b1);
    repeat (2) @(negedge clock);
    check("overrun_back_to_lo_loading", loading, 1'b1);
    check("overrun_back_to_lo_done", done, 1'b0);
    send_byte(8'h44, 2);
    push_word(1, 16'h3344);
    send_byte(8'h33, 0);
    wait_done("overrun_load_done");
    check("overrun_sticky", overrun, 1'b1);

    // DONE passthrough vectors, checked combinationally in the same cycle.
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      cpu_addr = pv[i].addr;
      cpu_wre  = pv[i].wre;
      #1;
      check("pass_addr", ram_addr, pv[i].addr);
      check("pass_wre", ram_wre, pv[i].wre);
      check("pass_bus_z", ram_data, 16'hFFFF);
    end
    @(negedge clock);
    cpu_wre = 1'b1;

    // Restart and a one-word load.
    pulse_start();
    check("restart_cpu_reset_n", cpu_reset_n, 1'b0);
    check("restart_loading", loading, 1'b1);
    check("restart_done", done, 1'b0);
    check("restart_overrun", overrun, 1'b0);
    send_byte(8'h01, 2);
    send_byte(8'h00, 2);
    send_byte(8'h78, 2);
    push_word(0, 16'h5678);
    send_byte(8'h56, 0);
    wait_done("restart_load_done");

    // Reset in the second PULSE cycle.
    pulse_start();
    send_byte(8'h01, 2);
    send_byte(8'h00, 2);
    send_byte(8'h11, 2);
    push_word(0, 16'h2211);
    send_byte(8'h22, 0);
    repeat (2) @(negedge clock);
    check("pre_reset_wre_low", ram_wre, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("midwrite_rst_wre", ram_wre, 1'b1);
    check("midwrite_rst_bus_z", ram_data, 16'hFFFF);
    check("midwrite_rst_loading", loading, 1'b1);
    check("midwrite_rst_addr", ram_addr, BASE);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    send_byte(8'h01, 2);
    send_byte(8'h00, 2);
    send_byte(8'hEF, 2);
    push_word(0, 16'hBEEF);
    send_byte(8'hBE, 0);
    wait_done("post_reset_load_done");
    repeat (2) @(negedge clock);
    check("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
